// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel packet stream mux with external-select or round-robin
// arbitration; the granted channel stays locked for a whole packet.
//
// state   | meaning
// ST_IDLE | no packet in flight; mode/sel sampled, arbitration runs
// ST_PKT  | channel 'grant' locked until its last beat transfers
module stream_mux_rr #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH-1:0]        in_last,
  output logic [N_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [SEL_W-1:0]       out_ch,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PKT  = 1'b1;

  logic [0:0]        state;
  logic [SEL_W-1:0]  grant;
  logic [SEL_W-1:0]  last_grant;
  logic [SEL_W-1:0]  rr_idx;
  logic              rr_found;
  logic              sel_ok;
  logic              grant_ready;
  logic              xfer;
  logic [DATA_W-1:0] grant_data;

  // sel can exceed N_CH-1 when N_CH is not a power of two
  assign sel_ok      = 32'(sel) < 32'(N_CH);
  assign grant_ready = !out_valid || out_ready;
  assign xfer        = (state == ST_PKT) && in_valid[grant] && grant_ready;
  assign busy        = (state == ST_PKT);

  always_comb begin
    in_ready = '0;
    if (state == ST_PKT) in_ready[grant] = grant_ready;
  end

  always_comb begin
    grant_data = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (grant == SEL_W'(c)) grant_data = in_data[c*DATA_W +: DATA_W];
    end
  end

  // Walk offsets from farthest to nearest so the nearest valid channel wins.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int i = N_CH; i >= 1; i--) begin
      if (in_valid[(int'(last_grant) + i) % N_CH]) begin
        rr_found = 1'b1;
        rr_idx   = SEL_W'((int'(last_grant) + i) % N_CH);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= SEL_W'(N_CH - 1);
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_ch     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!mode) begin
            if (sel_ok && in_valid[sel]) begin
              grant <= sel;
              state <= ST_PKT;
            end
          end else if (rr_found) begin
            grant <= rr_idx;
            state <= ST_PKT;
          end
        end
        ST_PKT: begin
          if (xfer && in_last[grant]) begin
            state      <= ST_IDLE;
            last_grant <= grant;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (xfer) begin
        out_data  <= grant_data;
        out_last  <= in_last[grant];
        out_ch    <= grant;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: packet-level reference model feeds a scoreboard
// that an independent monitor drains on every output handshake.
module tb_stream_mux_rr;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          mode;
  logic [SW-1:0] sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_valid, in_last, in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid, out_last, out_ready, busy;
  logic [SW-1:0] out_ch;

  stream_mux_rr #(.N_CH(N), .DATA_W(W)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ch(out_ch),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct { logic [W-1:0] data; logic last; } beat_t;
  typedef struct { logic [W-1:0] data; logic last; logic [SW-1:0] ch; } exp_t;

  beat_t src_q[N][$];
  beat_t mdl_q[N][$];
  exp_t  exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    lg = N - 1;

  logic          busy_s, ov_s, fire_last_s;
  logic [N-1:0]  fire_s;

  task automatic chk(input string name, input int got, input int expv);
    tests++;
    if (got != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic add_pkt(input int c, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = W'($urandom);
      b.last = (i == len - 1);
      src_q[c].push_back(b);
    end
  endtask

  task automatic drive_src();
    for (int c = 0; c < N; c++) begin
      if (src_q[c].size() > 0) begin
        in_valid[c]        = 1'b1;
        in_data[c*W +: W]  = src_q[c][0].data;
        in_last[c]         = src_q[c][0].last;
      end else begin
        in_valid[c]        = 1'b0;
        in_data[c*W +: W]  = W'($urandom);
        in_last[c]         = 1'($urandom);
      end
    end
  endtask

  task automatic take_pkt(input int c);
    beat_t b;
    exp_t  e;
    do begin
      b = mdl_q[c].pop_front();
      e.data = b.data; e.last = b.last; e.ch = SW'(c);
      exp_q.push_back(e);
    end while (!b.last && mdl_q[c].size() > 0);
    lg = c;
  endtask

  // Packet-level model: whole packets are granted in select or round-robin order.
  task automatic model(input bit m, input int s);
    int pick;
    for (int c = 0; c < N; c++) mdl_q[c] = src_q[c];
    if (!m) begin
      while (mdl_q[s].size() > 0) take_pkt(s);
    end else begin
      while (1) begin
        pick = -1;
        for (int i = 1; i <= N; i++)
          if (pick < 0 && mdl_q[(lg + i) % N].size() > 0) pick = (lg + i) % N;
        if (pick < 0) break;
        take_pkt(pick);
      end
    end
  endtask

  task automatic step();
    beat_t b;
    @(negedge sys_clk);
    busy_s = busy;
    ov_s   = out_valid;
    fire_s = in_valid & in_ready;
    @(posedge sys_clk);
    #1;
    fire_last_s = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (fire_s[c] && src_q[c].size() > 0) begin
        b = src_q[c].pop_front();
        if (b.last) fire_last_s = 1'b1;
      end
    end
  endtask

  task automatic run_phase(input bit m, input int s, input bit tog, input int rdy_pct, input bit stall);
    int k, stall_left;
    bit seen, stall_done;
    model(m, s);
    mode = m; sel = SW'(s); out_ready = 1'b1;
    drive_src();
    k = 0; seen = 0; stall_done = 0; stall_left = 0;
    while (exp_q.size() > 0 && k < 2000) begin
      step();
      if (!seen && ov_s) begin
        seen = 1;
        chk("first_beat_latency", k, 2);
      end
      if (tog && busy_s && !fire_last_s) begin
        mode = !m;
        sel  = SW'($urandom);
      end else begin
        mode = m;
        sel  = SW'(s);
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (stall && !stall_done && busy_s && ov_s) begin
        out_ready  = 1'b0;
        stall_left = 4;
        stall_done = 1;
      end else begin
        out_ready = ($urandom % 100) < rdy_pct;
      end
      drive_src();
      k++;
    end
    chk("phase_drained_remaining", exp_q.size(), 0);
    exp_q.delete();
    mode = m; sel = SW'(s); out_ready = 1'b1;
  endtask

  // Monitor: scoreboard pop on handshake, hold and ready checks under stall.
  logic            held = 1'b0;
  logic [W+SW:0]   held_v;
  always @(negedge sys_clk) begin
    exp_t e;
    if (sys_rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        tests++;
        if (!out_valid || {out_data, out_last, out_ch} != held_v) begin
          fails++;
          $display("FAIL out_hold: got v=%0b %0h expected v=1 %0h", out_valid,
                   {out_data, out_last, out_ch}, held_v);
        end
      end
      if (out_valid && !out_ready) begin
        tests++;
        if (in_ready != '0) begin
          fails++;
          $display("FAIL stall_in_ready: got %b expected 0000", in_ready);
        end
      end
      held   = out_valid && !out_ready;
      held_v = {out_data, out_last, out_ch};
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat: got data=%0h ch=%0d expected none", out_data, out_ch);
        end else begin
          e = exp_q.pop_front();
          if ({out_data, out_last, out_ch} != {e.data, e.last, e.ch}) begin
            fails++;
            $display("FAIL beat: got data=%0h last=%0b ch=%0d expected data=%0h last=%0b ch=%0d",
                     out_data, out_last, out_ch, e.data, e.last, e.ch);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b;
    sys_rst = 1'b1; mode = 1'b1; sel = '0; out_ready = 1'b1;
    in_valid = '1; in_last = '1; in_data = N*W'($urandom);
    @(posedge sys_clk); @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    drive_src();

    // round-robin fairness from reset: 0,1,2,3,0,...
    for (int c = 0; c < N; c++) begin add_pkt(c, 2); add_pkt(c, 2); end
    run_phase(1, 0, 0, 100, 0);

    // fixed select on channel 2 while channel 1 also waits
    b.last = 0; b.data = 8'h11; src_q[2].push_back(b);
    b.data = 8'h22; src_q[2].push_back(b);
    b.last = 1; b.data = 8'h33; src_q[2].push_back(b);
    add_pkt(1, 3);
    run_phase(0, 2, 0, 100, 0);
    run_phase(0, 1, 0, 100, 0);

    // last_grant=3, only channel 2 valid
    add_pkt(3, 1);
    run_phase(0, 3, 0, 100, 0);
    add_pkt(2, 2);
    run_phase(1, 0, 0, 100, 0);

    // single-beat packets back to back, then a 5-cycle stall mid-packet
    for (int c = 0; c < N; c++) add_pkt(c, 1);
    run_phase(1, 0, 0, 100, 0);
    for (int c = 0; c < N; c++) add_pkt(c, 5);
    run_phase(1, 0, 0, 100, 1);

    // mode/sel toggled during packets
    add_pkt(2, 4); add_pkt(2, 3); add_pkt(1, 2); add_pkt(3, 2);
    run_phase(0, 2, 1, 70, 0);
    for (int c = 0; c < N; c++) add_pkt(c, 1 + $urandom % 4);
    run_phase(1, 0, 1, 70, 1);

    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom % 2) add_pkt(c, 1 + $urandom % 4);
        if ($urandom % 3 == 0) add_pkt(c, 1 + $urandom % 3);
      end
      run_phase(1'($urandom), $urandom % N, 1'($urandom), 40 + $urandom % 61, 1'($urandom));
    end
    run_phase(1, 0, 0, 100, 0);

    // reset in the middle of a packet
    add_pkt(1, 6); add_pkt(0, 2);
    model(0, 1);
    mode = 1'b0; sel = 2'd1; out_ready = 1'b1;
    drive_src();
    for (int k = 0; k < 30 && src_q[1].size() > 3; k++) begin
      step();
      drive_src();
    end
    chk("rst_mid_busy_before", int'(busy), 1);
    sys_rst = 1'b1;
    for (int c = 0; c < N; c++) src_q[c].delete();
    exp_q.delete();
    drive_src();
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("rst_mid_out_valid", int'(out_valid), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_in_ready", int'(in_ready), 0);
    lg = N - 1;
    @(posedge sys_clk); #1;

    for (int c = 0; c < N; c++) add_pkt(c, 2);
    run_phase(1, 0, 0, 100, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
